// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel datapath: pixel/window widths, the window
// generator's state encoding and the (row, col) -> bit-offset helper.
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 72;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } sobel_state_e;

    // Bit offset of window element P[r][c]; top-left lands in the MSB byte.
    function automatic int unsigned win_off(input int unsigned r, input int unsigned c);
        return (8 - (3 * r + c)) * PIX_W;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels: combinational read, synchronous write at the same
// address, so a read in the write cycle returns the previous row's pixel.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting window,
// emitting one packed 72-bit window per interior pixel, one cycle registered.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PIX_W-1:0] i_pixel_data,
    input  logic             i_pixel_data_valid,
    output logic [WIN_W-1:0] o_pixel_data,
    output logic             o_pixel_data_valid,
    output logic             o_frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    sobel_state_e     state_q, state_d;
    logic             emit_q, emit_d;
    logic             done_q, done_d;
    logic             acc;
    logic             last_col, last_row;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    logic [PIX_W-1:0] win_q [3][3];
    logic [WIN_W-1:0] win_flat;

    // A pixel coinciding with reset is dropped.
    assign acc      = i_pixel_data_valid && !i_rst;
    assign last_col = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk_i  (i_clk),
        .we_i   (acc),
        .addr_i (col_q),
        .wdata_i(i_pixel_data),
        .rdata_o(lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .clk_i  (i_clk),
        .we_i   (acc),
        .addr_i (col_q),
        .wdata_i(lb1_rd),
        .rdata_o(lb2_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        emit_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            FILL: begin
                if (acc && row_q == RW'(2) && col_q == '0) state_d = STREAM;
            end
            STREAM: begin
                if (acc) begin
                    emit_d = (col_q >= CW'(2));
                    if (last_row && last_col) begin
                        state_d = FILL;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_flat[win_off(r, c) +: PIX_W] = win_q[r][c];
            end
        end
    end

    // Window contents are refilled before use, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= i_pixel_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q              <= '0;
            row_q              <= '0;
            state_q            <= FILL;
            emit_q             <= 1'b0;
            done_q             <= 1'b0;
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_frame_done       <= 1'b0;
        end else begin
            col_q              <= col_d;
            row_q              <= row_d;
            state_q            <= state_d;
            emit_q             <= emit_d;
            done_q             <= done_d;
            o_pixel_data_valid <= emit_q;
            o_frame_done       <= done_q;
            if (emit_q) o_pixel_data <= win_flat;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: a 4x4 instance and a 5x3 instance,
// checked against hand-computed window tables.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst4 = 1'b1, v4 = 1'b0;
    logic [7:0]       p4 = '0;
    logic [WIN_W-1:0] d4;
    logic             ov4, fd4;
    logic             rst53 = 1'b1, v53 = 1'b0;
    logic [7:0]       p53 = '0;
    logic [WIN_W-1:0] d53;
    logic             ov53, fd53;

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_pixel_data(p4), .i_pixel_data_valid(v4),
        .o_pixel_data(d4), .o_pixel_data_valid(ov4), .o_frame_done(fd4));

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut53 (
        .i_clk(clk), .i_rst(rst53), .i_pixel_data(p53), .i_pixel_data_valid(v53),
        .o_pixel_data(d53), .o_pixel_data_valid(ov53), .o_frame_done(fd53));

    typedef struct packed {
        logic [71:0] win;
        logic        done;
    } vec_t;

    typedef struct {
        logic [71:0] win;
        logic        done;
        int          cyc;
    } cap_t;

    vec_t tbl4  [4];
    vec_t tbl53 [3];
    cap_t cap4[$], cap53[$];
    int   acc4[$], acc53[$];
    int   done4, done53;
    int   cyc, checks, errors;

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (ov4)  cap4.push_back('{d4, fd4, cyc});
        if (fd4)  done4++;
        if (ov53) cap53.push_back('{d53, fd53, cyc});
        if (fd53) done53++;
    endtask

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear();
        cap4.delete();  acc4.delete();  done4 = 0;
        cap53.delete(); acc53.delete(); done53 = 0;
    endtask

    task automatic send4(input logic [7:0] px, input bit emit);
        p4 = px; v4 = 1'b1;
        step();
        v4 = 1'b0;
        if (emit) acc4.push_back(cyc);
    endtask

    task automatic frame4(input logic [7:0] off, input bit gaps);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) step();
                send4(off + 8'(16 * r + c), (r >= 2) && (c >= 2));
            end
        end
    endtask

    task automatic verify(input string nm, input bit sel53, input int nexp,
                          input logic [7:0] off_a, input logic [7:0] off_b, input int exp_done);
        cap_t c;
        vec_t e;
        int   n, acc;
        logic [71:0] offv;
        n = sel53 ? cap53.size() : cap4.size();
        chk({nm, " window count"}, 72'(n), 72'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (i < n) begin
                c    = sel53 ? cap53[i] : cap4[i];
                e    = sel53 ? tbl53[i] : tbl4[i % 4];
                acc  = sel53 ? acc53[i] : acc4[i];
                offv = {9{(i < 4) ? off_a : off_b}};
                chk($sformatf("%s win%0d data", nm, i), c.win, e.win + offv);
                chk($sformatf("%s win%0d done", nm, i), 72'(c.done), 72'(e.done));
                chk($sformatf("%s win%0d latency", nm, i), 72'(c.cyc), 72'(acc + 1));
            end
        end
        chk({nm, " frame_done pulses"}, 72'(sel53 ? done53 : done4), 72'(exp_done));
    endtask

    initial begin
        tbl4[0]  = '{72'h00_01_02_10_11_12_20_21_22, 1'b0};
        tbl4[1]  = '{72'h01_02_03_11_12_13_21_22_23, 1'b0};
        tbl4[2]  = '{72'h10_11_12_20_21_22_30_31_32, 1'b0};
        tbl4[3]  = '{72'h11_12_13_21_22_23_31_32_33, 1'b1};
        tbl53[0] = '{72'h00_01_02_10_11_12_20_21_22, 1'b0};
        tbl53[1] = '{72'h01_02_03_11_12_13_21_22_23, 1'b0};
        tbl53[2] = '{72'h02_03_04_12_13_14_22_23_24, 1'b1};
        cyc = 0; checks = 0; errors = 0;
        clear();

        // Reset state
        repeat (2) step();
        chk("reset data4", d4, '0);
        chk("reset valid4", 72'(ov4), '0);
        chk("reset done4", 72'(fd4), '0);
        chk("reset data53", d53, '0);
        chk("reset valid53", 72'(ov53), '0);
        chk("reset col4", 72'(dut4.col_q), '0);
        rst4 = 1'b0; rst53 = 1'b0;
        step();

        // Basic continuous frame
        clear();
        frame4(8'h00, 1'b0);
        repeat (3) step();
        verify("basic", 1'b0, 4, 8'h00, 8'h00, 1);

        // Same frame with random idle gaps
        clear();
        frame4(8'h00, 1'b1);
        repeat (3) step();
        verify("gapped", 1'b0, 4, 8'h00, 8'h00, 1);

        // Back-to-back frames, no idle cycles between them
        clear();
        frame4(8'h00, 1'b0);
        frame4(8'h80, 1'b0);
        repeat (3) step();
        verify("b2b", 1'b0, 8, 8'h00, 8'h80, 2);

        // Row boundary on the 5x3 instance
        clear();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                p53 = 8'(16 * r + c); v53 = 1'b1;
                step();
                v53 = 1'b0;
                if (r == 2 && c >= 2) acc53.push_back(cyc);
            end
        end
        repeat (3) step();
        verify("row_bound", 1'b1, 3, 8'h00, 8'h00, 1);

        // Reset mid-frame at pixel (2,1), then a full new frame
        clear();
        for (int i = 0; i < 9; i++) send4(8'(16 * (i / 4) + (i % 4)), 1'b0);
        p4 = 8'h21; v4 = 1'b1; rst4 = 1'b1;
        step();
        chk("midrst data", d4, '0);
        chk("midrst valid", 72'(ov4), '0);
        chk("midrst done", 72'(fd4), '0);
        rst4 = 1'b0; v4 = 1'b0;
        step();
        clear();
        frame4(8'h40, 1'b0);
        repeat (3) step();
        verify("after_rst", 1'b0, 4, 8'h40, 8'h40, 1);

        // Reset coincident with valid: pixel dropped
        clear();
        send4(8'h55, 1'b0);
        p4 = 8'hFF; v4 = 1'b1; rst4 = 1'b1;
        step();
        chk("coinc col", 72'(dut4.col_q), '0);
        chk("coinc row", 72'(dut4.row_q), '0);
        chk("coinc valid", 72'(ov4), '0);
        rst4 = 1'b0; v4 = 1'b0;
        step();
        chk("coinc valid2", 72'(ov4), '0);
        send4(8'h00, 1'b0);
        chk("coinc col after one", 72'(dut4.col_q), 72'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator feeding the Sobel edge stage. It accepts one 8-bit greyscale pixel per valid cycle in raster order. It buffers the two previous image rows and emits, for every pixel whose full 3x3 neighbourhood lies inside the frame, the 72-bit window in the packing the Sobel stage consumes. The block sits between the pixel source and the Sobel stage; its outputs wire straight into the Sobel stage's pixel data and valid inputs.

## Interface
- IMG_WIDTH, 512: pixels per row; legal range ≥ 3.
- IMG_HEIGHT, 512: rows per frame; legal range ≥ 3.
- i_clk  input  1  sole clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_pixel_data  input  8  unsigned pixel, raster order.
- i_pixel_data_valid  input  1  qualifies i_pixel_data; may drop for any number of cycles.
- o_pixel_data  output  72  3x3 window.
- o_pixel_data_valid  output  1  qualifies o_pixel_data; single-cycle per window.
- o_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- One clock; reset is synchronous and active-high.
- Column counter `col` runs 0..IMG_WIDTH-1. Row counter `row` runs 0..IMG_HEIGHT-1. Both are sized $clog2 of their limit.
  - They advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- Two line buffers, LB1 (row-1) and LB2 (row-2), each IMG_WIDTH x 8 with combinational read.
  - On an accepted pixel at column c: read LB1[c] and LB2[c]; write LB2[c] <= LB1[c] and LB1[c] <= pixel (read-before-write).
- Window registers P[r][c] with r = 0 top and c = 0 left.
  - On an accepted pixel, columns shift left.
  - The new right column is P[0][2] = LB2[c], P[1][2] = LB1[c], P[2][2] = pixel.
- Packing: o_pixel_data[(8-(3r+c))*8 +: 8] = P[r][c]. Top-left occupies [71:64]; bottom-right occupies [7:0].
- FSM states:
  - FILL: entered on reset and after frame wrap. Stays here while row < 2. Emits no windows.
  - STREAM: entered on acceptance of the first pixel of row 2. Returns to FILL on acceptance of the last pixel of the frame.
- Window emit condition: state STREAM and col ≥ 2 at the accepted pixel. Windows never straddle rows, because col 0 and col 1 of every row emit nothing.
- Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- While i_pixel_data_valid = 0: counters, buffers, window and FSM hold.
- o_pixel_data holds its last value when valid is low.

## Timing
- Reset values: o_pixel_data = 0, o_pixel_data_valid = 0, o_frame_done = 0, col = 0, row = 0, state = FILL.
- Line buffer and window contents are not cleared by reset; they are don't-care because they are refilled before use.
- Latency: exactly 1 cycle. The window containing the pixel accepted at edge N is valid after edge N+1.
- o_frame_done asserts in the same cycle as the final window's valid.
- Back-to-back frames with no idle cycles are legal. Row 0 of the next frame is accepted in the cycle after the last pixel.
- Reset mid-frame: the next accepted pixel is treated as (0,0). No window is emitted until row 2, col 2 of the new frame.
- Reset and valid together: reset wins and the pixel is dropped.
- No backpressure. The downstream Sobel stage is always ready.

## Structure
- Shared package `sobel_pkg`:
  - PIX_W = 8.
  - WIN_W = 72.
  - State enum {FILL, STREAM}.
  - Byte-index helper for (r, c) to bit offset, reused by the Sobel stage and its bench.
- One sub-module, `line_buffer`: a parameterised IMG_WIDTH x 8 register array with combinational read and synchronous write, instantiated twice.
- Counters, FSM and window registers stay in `sobel_window_gen`.

## Test plan
- Basic window: IMG_WIDTH = IMG_HEIGHT = 4, pixel = 16*row+col, continuous valid.
  - First valid window is 0x00_01_02_10_11_12_20_21_22, one cycle after pixel (2,2) is accepted.
  - Exactly 4 windows are produced.
  - o_frame_done pulses once, together with the window 0x11_12_13_21_22_23_31_32_33.
- Gapped input: same image with valid toggling 1-0-0-1 randomly.
  - Identical window sequence and values to the basic case.
  - Each window appears exactly 1 cycle after its pixel is accepted.
- Row boundary: IMG_WIDTH = 5, IMG_HEIGHT = 3.
  - Pixels at col 0 and col 1 of row 2 produce no valid.
  - Windows are centred only on (1,1), (1,2), (1,3); 3 in total.
- Back-to-back frames: two 4x4 frames with different pixel offsets (+0x00, +0x80), no idle cycles.
  - 8 windows in total.
  - The first window of frame 2 is 0x80_81_82_90_91_92_A0_A1_A2; no stale rows from frame 1.
- Reset mid-frame: assert i_rst at pixel (2,1) of a 4x4 frame, then send a full new frame.
  - Outputs go to 0 the cycle after reset.
  - Exactly 4 windows from the new frame are produced.
- Reset coincident with valid: the pixel is dropped, counters read 0, and no valid is asserted.
